// File: rtl/quadrilatero_pkg.sv
// Shared types and sizes for the quadrilatero matrix coprocessor.
// Memory-port width and the arbiter state encoding live here.
package quadrilatero_pkg;

  localparam int unsigned BUS_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } arb_state_e;

endpackage

// File: rtl/quadrilatero_rr_picker.sv
// Combinational round-robin picker: first set request at or
// after ptr_i, wrapping modulo N_REQ (need not be a power of two).
module quadrilatero_rr_picker #(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic                     valid_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);

  localparam int unsigned IW = $clog2(N_REQ);

  logic [IW:0] pos;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = {1'b0, ptr_i} + (IW+1)'(i);
      if (pos >= (IW+1)'(N_REQ)) begin
        pos = pos - (IW+1)'(N_REQ);
      end
      if (!valid_o && req_i[pos[IW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/quadrilatero_mem_arbiter.sv
// Round-robin arbiter sharing the single-outstanding bridge port
// between N_REQ requesters, with a response watchdog.
module quadrilatero_mem_arbiter #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned BUS_WIDTH      = quadrilatero_pkg::BUS_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_REQ-1:0]             req_i,
  input  logic [N_REQ-1:0]             we_i,
  input  logic [N_REQ*BUS_WIDTH/8-1:0] be_i,
  input  logic [N_REQ*32-1:0]          addr_i,
  input  logic [N_REQ*BUS_WIDTH-1:0]   wdata_i,
  output logic [N_REQ-1:0]             gnt_o,
  output logic [N_REQ-1:0]             rvalid_o,
  output logic [BUS_WIDTH-1:0]         rdata_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [BUS_WIDTH/8-1:0]       mem_be_o,
  output logic [31:0]                  mem_addr_o,
  output logic [BUS_WIDTH-1:0]         mem_wdata_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [BUS_WIDTH-1:0]         mem_rdata_i,
  output logic                         busy_o,
  output logic                         err_o
);

  import quadrilatero_pkg::*;

  localparam int unsigned IW  = $clog2(N_REQ);
  localparam int unsigned BEW = BUS_WIDTH / 8;
  localparam int unsigned CW  =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LIM =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0]    CNT_MAX = '1;
  localparam logic [IW-1:0]    LAST    = IW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE     = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_e    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] sel;
  logic          pick_valid;
  logic [CW-1:0] cnt;
  logic          issue;
  logic          grant;
  logic          resp;

  quadrilatero_rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_i   (req_i),
    .ptr_i   (rr_ptr),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Arbitration only moves in IDLE; afterwards the owner is locked.
  always_comb begin
    sel   = owner;
    issue = 1'b0;
    unique case (state)
      IDLE: begin
        sel   = pick_idx;
        issue = pick_valid;
      end
      WAIT_GNT: issue = req_i[owner];
      default:  issue = 1'b0;
    endcase
    issue = issue & rst_ni;
  end

  assign grant = issue & mem_gnt_i;
  assign resp  = rst_ni & mem_rvalid_i & (state == WAIT_RVALID);

  assign mem_req_o   = issue;
  assign mem_we_o    = issue & we_i[sel];
  assign mem_be_o    = issue ? be_i[sel*BEW +: BEW] : '0;
  assign mem_addr_o  = issue ? addr_i[sel*32 +: 32] : '0;
  assign mem_wdata_o = issue ? wdata_i[sel*BUS_WIDTH +: BUS_WIDTH] : '0;

  assign gnt_o    = grant ? (ONE << sel) : '0;
  assign rvalid_o = resp ? (ONE << owner) : '0;
  assign rdata_o  = resp ? mem_rdata_i : '0;
  assign busy_o   = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      cnt    <= '0;
      err_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick_idx;
            state <= mem_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (grant) state <= WAIT_RVALID;
        end
        WAIT_RVALID: begin
          if (mem_rvalid_i) begin
            rr_ptr <= (owner == LAST) ? '0 : owner + 1'b1;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (TIMEOUT_CYCLES != 0 && cnt >= CNT_LIM) err_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_hold_req: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (state == WAIT_GNT) |-> req_i[owner]
  );

  a_stray_rvalid: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> (state == WAIT_RVALID)
  );

endmodule
